// File: rtl/wb_slave_pkg.sv
// Shared types and widths for the Wishbone SRAM responder.
package wb_slave_pkg;

   localparam int unsigned WB_DAT_W = 32;
   localparam int unsigned WB_ADR_W = 32;
   localparam int unsigned WB_SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } wb_state_t;

   typedef struct packed {
      logic [WB_ADR_W-1:0] adr;
      logic [WB_DAT_W-1:0] dat;
      logic [WB_SEL_W-1:0] sel;
      logic                we;
   } wb_req_t;

   // Expand byte-lane enables into a per-bit write mask.
   function automatic logic [WB_DAT_W-1:0] sel_to_mask(input logic [WB_SEL_W-1:0] sel);
      logic [WB_DAT_W-1:0] mask;
      mask = '0;
      for (int unsigned b = 0; b < WB_SEL_W; b++) begin
         mask[8*b +: 8] = {8{sel[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone classic bus between the core master and the SRAM responder.
interface wb_sram_slave_if;
   import wb_slave_pkg::*;

   logic [WB_ADR_W-1:0] i_wb_adr;
   logic [WB_DAT_W-1:0] i_wb_dat;
   logic [WB_SEL_W-1:0] i_wb_sel;
   logic                i_wb_we;
   logic                i_wb_cyc;
   logic                i_wb_stb;
   logic [WB_DAT_W-1:0] o_wb_dat;
   logic                o_wb_ack;
   logic                o_wb_err;

   modport master (
      output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
      input  o_wb_dat, o_wb_ack, o_wb_err
   );

   modport slave (
      input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
      output o_wb_dat, o_wb_ack, o_wb_err
   );

endinterface

// File: rtl/wb_sram_mem.sv
// DEPTH x 32 word store: reset-cleared, byte-lane writes, registered read port.
module wb_sram_mem
   import wb_slave_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic                re,
   input  logic [IDX_W-1:0]    idx,
   input  logic [WB_DAT_W-1:0] wdat,
   input  logic [WB_SEL_W-1:0] sel,
   output logic [WB_DAT_W-1:0] rdat
);

   logic [WB_DAT_W-1:0] words [DEPTH];
   logic [WB_DAT_W-1:0] mask;

   assign mask = sel_to_mask(sel);

   // One register per word so the whole array clears on reset.
   for (genvar w = 0; w < DEPTH; w++) begin : g_word
      logic [WB_DAT_W-1:0] word_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            word_q <= '0;
         end else if (we && (idx == IDX_W'(w))) begin
            word_q <= (word_q & ~mask) | (wdat & mask);
         end
      end

      assign words[w] = word_q;
   end

   // Read data is zero except on the cycle following a read strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdat <= '0;
      end else begin
         rdat <= re ? words[idx] : '0;
      end
   end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic responder backing an on-chip SRAM with programmable wait states.
module wb_sram_slave
   import wb_slave_pkg::*;
#(
   parameter int unsigned         DEPTH       = 256,
   parameter int unsigned         WAIT_STATES = 0,
   parameter logic [WB_ADR_W-1:0] BASE_ADR    = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   wb_sram_slave_if.slave wb
);

   localparam int unsigned         IDX_W    = $clog2(DEPTH);
   localparam int unsigned         CNT_W    = 4;
   localparam logic [WB_ADR_W-1:0] WIN_MASK = WB_ADR_W'(DEPTH * 4 - 1);

   wb_state_t           state;
   logic [CNT_W-1:0]    wait_cnt;
   wb_req_t             req;
   logic                ack;
   logic                err;
   logic                in_range;
   logic                aligned;
   logic                req_ok;
   logic                mem_we;
   logic                mem_re;
   logic [IDX_W-1:0]    idx;
   logic [WB_DAT_W-1:0] rdat;

   // Decode of the captured request; memory access happens on the edge leaving RESP.
   always_comb begin
      in_range = (req.adr & ~WIN_MASK) == BASE_ADR;
      aligned  = req.adr[1:0] == 2'b00;
      req_ok   = in_range && aligned;
      idx      = req.adr[IDX_W+1:2];
      mem_we   = (state == RESP) && req_ok && req.we;
      mem_re   = (state == RESP) && req_ok && !req.we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         req      <= '0;
         ack      <= 1'b0;
         err      <= 1'b0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (wb.i_wb_cyc && wb.i_wb_stb) begin
                  req.adr  <= wb.i_wb_adr;
                  req.dat  <= wb.i_wb_dat;
                  req.sel  <= wb.i_wb_sel;
                  req.we   <= wb.i_wb_we;
                  wait_cnt <= CNT_W'(WAIT_STATES);
                  state    <= (WAIT_STATES > 0) ? WAIT : RESP;
               end
            end
            WAIT: begin
               // Master withdrawing the request abandons it silently.
               if (!(wb.i_wb_cyc && wb.i_wb_stb)) begin
                  wait_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
                  if (wait_cnt == CNT_W'(1)) begin
                     state <= RESP;
                  end
               end
            end
            RESP: begin
               ack   <= req_ok;
               err   <= !req_ok;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   wb_sram_mem #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk  (clk),
      .rst  (rst),
      .we   (mem_we),
      .re   (mem_re),
      .idx  (idx),
      .wdat (req.dat),
      .sel  (req.sel),
      .rdat (rdat)
   );

   assign wb.o_wb_dat = rdat;
   assign wb.o_wb_ack = ack;
   assign wb.o_wb_err = err;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: two instances (no wait states / three wait states) against a transaction model.
module tb_wb_sram_slave;

   localparam int unsigned D0_DEPTH = 256;
   localparam int unsigned D1_DEPTH = 16;
   localparam int unsigned D1_WS    = 3;
   localparam logic [31:0] D1_BASE  = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int checks   = 0;
   int failures = 0;

   logic [1:0]  b_cyc, b_stb, b_we;
   logic [31:0] b_adr [2];
   logic [31:0] b_dat [2];
   logic [3:0]  b_sel [2];
   logic [1:0]  o_ack, o_err;
   logic [31:0] o_dat [2];

   wb_sram_slave_if wb0();
   wb_sram_slave_if wb1();

   assign wb0.i_wb_adr = b_adr[0];
   assign wb0.i_wb_dat = b_dat[0];
   assign wb0.i_wb_sel = b_sel[0];
   assign wb0.i_wb_we  = b_we[0];
   assign wb0.i_wb_cyc = b_cyc[0];
   assign wb0.i_wb_stb = b_stb[0];
   assign wb1.i_wb_adr = b_adr[1];
   assign wb1.i_wb_dat = b_dat[1];
   assign wb1.i_wb_sel = b_sel[1];
   assign wb1.i_wb_we  = b_we[1];
   assign wb1.i_wb_cyc = b_cyc[1];
   assign wb1.i_wb_stb = b_stb[1];
   assign o_ack[0] = wb0.o_wb_ack;
   assign o_err[0] = wb0.o_wb_err;
   assign o_dat[0] = wb0.o_wb_dat;
   assign o_ack[1] = wb1.o_wb_ack;
   assign o_err[1] = wb1.o_wb_err;
   assign o_dat[1] = wb1.o_wb_dat;

   wb_sram_slave #(.DEPTH(D0_DEPTH), .WAIT_STATES(0), .BASE_ADR(32'h0000_0000)) dut0 (
      .clk (clk), .rst (rst), .wb (wb0));
   wb_sram_slave #(.DEPTH(D1_DEPTH), .WAIT_STATES(D1_WS), .BASE_ADR(D1_BASE)) dut1 (
      .clk (clk), .rst (rst), .wb (wb1));

   // Transaction-level model: word memory per instance plus the response due on a given cycle.
   typedef struct {
      int unsigned at;
      logic        ack;
      logic        err;
      logic [31:0] dat;
   } exp_t;

   logic [31:0] mdl [2][256];
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        ce;

   function automatic int unsigned depth_of(input int d);
      return (d == 0) ? D0_DEPTH : D1_DEPTH;
   endfunction

   function automatic int unsigned ws_of(input int d);
      return (d == 0) ? 0 : D1_WS;
   endfunction

   function automatic logic [31:0] base_of(input int d);
      return (d == 0) ? 32'h0000_0000 : D1_BASE;
   endfunction

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++)
            mdl[d][i] = 32'h0;
   endtask

   // A request captured on edge n is answered in the cycle after edge n+1+WAIT_STATES.
   task automatic model_req(input int d, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] s, input int unsigned n);
      exp_t        e;
      longint      lo, hi;
      bit          ok;
      int unsigned i;
      lo = longint'(base_of(d));
      hi = lo + longint'(depth_of(d)) * 4;
      ok = (longint'(a) >= lo) && (longint'(a) < hi) && ((a % 4) == 0);
      e.at  = n + 1 + ws_of(d);
      e.ack = ok;
      e.err = !ok;
      e.dat = 32'h0;
      if (ok) begin
         i = (a - base_of(d)) / 4;
         if (w) begin
            for (int b = 0; b < 4; b++) begin
               if (s[b]) mdl[d][i][8*b +: 8] = wd[8*b +: 8];
            end
         end else begin
            e.dat = mdl[d][i];
         end
      end
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Every cycle: outputs must equal the response due now, or all zero.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         ce = '{at: 0, ack: 1'b0, err: 1'b0, dat: 32'h0};
         if (d == 0 && q0.size() > 0 && q0[0].at == edge_cnt) ce = q0.pop_front();
         if (d == 1 && q1.size() > 0 && q1[0].at == edge_cnt) ce = q1.pop_front();
         checks++;
         if ({o_ack[d], o_err[d], o_dat[d]} !== {ce.ack, ce.err, ce.dat}) begin
            failures++;
            $display("FAIL resp%0d edge=%0d: got ack=%b err=%b dat=%h, want ack=%b err=%b dat=%h",
                     d, edge_cnt, o_ack[d], o_err[d], o_dat[d], ce.ack, ce.err, ce.dat);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
      b_cyc[d] = 1'b1; b_stb[d] = 1'b1; b_we[d] = w;
      b_adr[d] = a;    b_dat[d] = wd;   b_sel[d] = s;
   endtask

   task automatic bus_idle(input int d);
      b_cyc[d] = 1'b0; b_stb[d] = 1'b0; b_we[d] = 1'b0;
      b_adr[d] = 32'h0; b_dat[d] = 32'h0; b_sel[d] = 4'h0;
   endtask

   // Single classic-cycle transfer; lat is the edge offset from capture to the ACK/ERR cycle.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, output logic r_ack, output logic r_err,
                       output logic [31:0] r_dat, output int unsigned lat);
      int unsigned n;
      bit          done;
      r_ack = 1'b0; r_err = 1'b0; r_dat = 32'h0; lat = 0; done = 1'b0;
      @(negedge clk);
      drive(d, w, a, wd, s);
      @(posedge clk); #1;
      n = edge_cnt;
      model_req(d, w, a, wd, s, n);
      for (int k = 0; k < int'(ws_of(d)) + 4 && !done; k++) begin
         @(negedge clk); #1;
         if (o_ack[d] || o_err[d]) begin
            r_ack = o_ack[d]; r_err = o_err[d]; r_dat = o_dat[d];
            lat = edge_cnt - n;
            done = 1'b1;
         end
      end
      bus_idle(d);
      if (!done) begin
         checks++; failures++;
         $display("FAIL timeout%0d adr=%h: got no ACK/ERR, want one", d, a);
      end
   endtask

   task automatic reset_assert();
      q0.delete();
      q1.delete();
      clear_model();
      bus_idle(0);
      bus_idle(1);
      rst = 1'b1;
   endtask

   task automatic reset_release();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic        xa, xe;
      logic [31:0] xd;
      int unsigned lat, n;
      int unsigned ack_edge [4];
      logic [31:0] b2b_adr [4];
      logic [31:0] b2b_exp [4];
      int          k;

      bus_idle(0);
      bus_idle(1);
      clear_model();
      ack_edge = '{0, 0, 0, 0};
      b2b_adr  = '{32'h10, 32'h20, 32'h3FC, 32'h0};
      b2b_exp  = '{32'hDEADBEEF, 32'h00BB00DD, 32'h12345678, 32'h0};

      repeat (3) @(negedge clk);
      chk("reset ack0", 32'(o_ack[0]), 32'd0);
      chk("reset err0", 32'(o_err[0]), 32'd0);
      chk("reset dat0", o_dat[0], 32'h0);
      chk("reset ack1", 32'(o_ack[1]), 32'd0);
      chk("reset dat1", o_dat[1], 32'h0);
      rst = 1'b0;

      // No wait states: full write, read back, byte lanes.
      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, xa, xe, xd, lat);
      chk("ws0 write ack", 32'(xa), 32'd1);
      chk("ws0 write err", 32'(xe), 32'd0);
      chk("ws0 write dat", xd, 32'h0);
      chk("ws0 latency", lat, 32'd1);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("ws0 read ack", 32'(xa), 32'd1);
      chk("ws0 read dat", xd, 32'hDEADBEEF);
      xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, xa, xe, xd, lat);
      xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("byte lane read", xd, 32'h00BB00DD);
      xfer(0, 1'b1, 32'h30, 32'h87654321, 4'b0000, xa, xe, xd, lat);
      chk("sel none ack", 32'(xa), 32'd1);

      // Error terminations and the top word.
      xfer(0, 1'b0, 32'h13, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("misaligned err", 32'(xe), 32'd1);
      chk("misaligned ack", 32'(xa), 32'd0);
      chk("misaligned dat", xd, 32'h0);
      xfer(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, xa, xe, xd, lat);
      chk("past end err", 32'(xe), 32'd1);
      xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("word0 untouched", xd, 32'h0);
      xfer(0, 1'b1, 32'h3FC, 32'h12345678, 4'hF, xa, xe, xd, lat);
      chk("top word write ack", 32'(xa), 32'd1);
      xfer(0, 1'b0, 32'h3FC, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("top word read", xd, 32'h12345678);

      // Back-to-back reads with stb held: one capture every second edge.
      @(negedge clk);
      drive(0, 1'b0, b2b_adr[0], 32'h0, 4'hF);
      @(posedge clk); #1;
      n = edge_cnt;
      for (int j = 0; j < 4; j++) model_req(0, 1'b0, b2b_adr[j], 32'h0, 4'hF, n + 2 * j);
      k = 0;
      for (int t = 0; t < 20 && k < 4; t++) begin
         @(negedge clk); #1;
         if (o_ack[0]) begin
            ack_edge[k] = edge_cnt;
            chk("b2b dat", o_dat[0], b2b_exp[k]);
            k++;
            if (k < 4) drive(0, 1'b0, b2b_adr[k], 32'h0, 4'hF);
            else       bus_idle(0);
         end
      end
      bus_idle(0);
      chk("b2b ack count", 32'(k), 32'd4);
      chk("b2b first latency", ack_edge[0] - n, 32'd1);
      for (int j = 1; j < 4; j++) chk("b2b spacing", ack_edge[j] - ack_edge[j-1], 32'd2);

      // Three wait states, abort, window bounds on a non-zero base.
      xfer(1, 1'b1, 32'h1004, 32'h11223344, 4'hF, xa, xe, xd, lat);
      chk("ws3 write ack", 32'(xa), 32'd1);
      chk("ws3 write latency", lat, 32'd4);
      xfer(1, 1'b0, 32'h1004, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("ws3 read latency", lat, 32'd4);
      chk("ws3 read dat", xd, 32'h11223344);
      @(negedge clk);
      drive(1, 1'b1, 32'h1004, 32'hFFFFFFFF, 4'hF);
      @(posedge clk);
      @(posedge clk); #1;
      bus_idle(1);
      repeat (6) @(negedge clk);
      xfer(1, 1'b0, 32'h1004, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("after abort dat", xd, 32'h11223344);
      xfer(1, 1'b1, 32'h1040, 32'hA5A5A5A5, 4'hF, xa, xe, xd, lat);
      chk("ws3 past end err", 32'(xe), 32'd1);
      xfer(1, 1'b0, 32'h0FFC, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("ws3 below base err", 32'(xe), 32'd1);
      xfer(1, 1'b0, 32'h1000, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("ws3 word0 untouched", xd, 32'h0);
      xfer(1, 1'b0, 32'h103C, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("ws3 top word ack", 32'(xa), 32'd1);

      // Reset landing on an ACK cycle clears outputs without waiting for a clock.
      @(negedge clk);
      drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
      @(posedge clk); #1;
      n = edge_cnt;
      model_req(0, 1'b0, 32'h10, 32'h0, 4'hF, n);
      @(posedge clk); #2;
      chk("ack before reset", 32'(o_ack[0]), 32'd1);
      chk("dat before reset", o_dat[0], 32'hDEADBEEF);
      reset_assert();
      #1;
      chk("async clear ack0", 32'(o_ack[0]), 32'd0);
      chk("async clear dat0", o_dat[0], 32'h0);
      reset_release();

      // Reset in the middle of a waited write drops it.
      xfer(1, 1'b1, 32'h1008, 32'hCAFEF00D, 4'hF, xa, xe, xd, lat);
      chk("pre-reset write ack", 32'(xa), 32'd1);
      @(negedge clk);
      drive(1, 1'b1, 32'h1008, 32'h55555555, 4'hF);
      @(posedge clk);
      @(posedge clk); #2;
      reset_assert();
      #1;
      chk("mid-wait reset ack1", 32'(o_ack[1]), 32'd0);
      chk("mid-wait reset err1", 32'(o_err[1]), 32'd0);
      chk("mid-wait reset dat1", o_dat[1], 32'h0);
      reset_release();
      xfer(1, 1'b0, 32'h1008, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("dropped write ack", 32'(xa), 32'd1);
      chk("dropped write dat", xd, 32'h0);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("cleared word", xd, 32'h0);
      xfer(0, 1'b0, 32'h44, 32'h0, 4'hF, xa, xe, xd, lat);
      chk("never written word", xd, 32'h0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
